// File: rtl/computer_system_pio_in_edge.sv
// Avalon-MM input PIO: synchronised level read-back, sticky per-bit edge capture
// with write-1-to-clear, and a masked level interrupt.
module computer_system_pio_in_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       arm_q, arm_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] edge_raw, edge_evt;
  logic             wr_en;
  logic             armed;
  logic             unused_wdata;

  assign data_sync    = sync_q[SYNC_STAGES-1];
  assign armed        = (arm_q == ARM_MAX);
  assign wr_en        = chipselect & write;
  assign unused_wdata = ^writedata;

  generate
    if (EDGE_MODE == 0) begin : g_rise
      assign edge_raw = data_sync & ~prev_q;
    end else if (EDGE_MODE == 1) begin : g_fall
      assign edge_raw = ~data_sync & prev_q;
    end else begin : g_any
      assign edge_raw = data_sync ^ prev_q;
    end
  endgenerate

  // Edges are ignored until the chain and data_prev have flushed the reset zeros.
  assign edge_evt = armed ? edge_raw : '0;

  always_comb begin
    arm_d  = armed ? arm_q : arm_q + 3'd1;
    mask_d = mask_q;
    cap_d  = cap_q;
    rd_d   = '0;
    if (wr_en && address == 2'd2) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd3) begin
      cap_d = cap_q & ~writedata[WIDTH-1:0];
    end
    // A fresh edge wins over a simultaneous clear of the same bit.
    cap_d = cap_d | edge_evt;
    case (address)
      2'd0:    rd_d[WIDTH-1:0] = data_sync;
      2'd2:    rd_d[WIDTH-1:0] = mask_q;
      2'd3:    rd_d[WIDTH-1:0] = cap_q;
      default: rd_d            = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      rd_q   <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= data_sync;
      arm_q  <= arm_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_computer_system_pio_in_edge.sv
// Scoreboarded bench for three PIO variants sharing one Avalon bus:
// A = 8b rising, B = 8b falling, C = 32b any-edge with a 3-stage synchroniser.
module tb_computer_system_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [7:0]  in_a, in_b;
  logic [31:0] in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  always #5 clk = ~clk;

  computer_system_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(0)) u_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));
  computer_system_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(1)) u_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));
  computer_system_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_MODE(2)) u_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c));

  typedef struct {
    int          dut;
    logic [31:0] rd;
    logic        irq;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic rd_req = 1'b0;
  logic rd_valid = 1'b0;

  always @(posedge clk) rd_valid <= rd_req;

  // Monitor: a read issued before edge N presents readdata after edge N.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: readdata presented with no expected entry");
      end else begin
        exp_t e;
        logic [31:0] act_rd;
        logic        act_irq;
        e = exp_q.pop_front();
        case (e.dut)
          0:       begin act_rd = rd_a; act_irq = irq_a; end
          1:       begin act_rd = rd_b; act_irq = irq_b; end
          default: begin act_rd = rd_c; act_irq = irq_c; end
        endcase
        checks += 2;
        $display("rd %-14s dut=%0d readdata=%h irq=%b", e.name, e.dut, act_rd, act_irq);
        if (act_rd !== e.rd) begin
          errors++;
          $display("FAIL %s readdata: got %h expected %h", e.name, act_rd, e.rd);
        end
        if (act_irq !== e.irq) begin
          errors++;
          $display("FAIL %s irq: got %b expected %b", e.name, act_irq, e.irq);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input int dut, input logic [1:0] a, input logic [31:0] exp_rd,
                    input logic exp_irq, input string name);
    exp_t e;
    e.dut = dut; e.rd = exp_rd; e.irq = exp_irq; e.name = name;
    exp_q.push_back(e);
    address = a;
    rd_req  = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    $display("wr addr=%0d data=%h", a, d);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    $display("chk %-14s got=%h", name, act);
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write = 1'b0; writedata = '0;
    in_a = 8'hFF; in_b = 8'hFF; in_c = 32'hFFFF_FFFF;
    idle(2);
    rd(0, 2'd0, 32'h0, 1'b0, "reset_rd_a");
    reset = 1'b0;
    idle(6);

    // Inputs held high through reset must not register as edges.
    rd(0, 2'd3, 32'h0, 1'b0, "cap_hold_a");
    rd(2, 2'd3, 32'h0, 1'b0, "cap_hold_c");
    rd(1, 2'd3, 32'h0, 1'b0, "cap_hold_b");
    rd(0, 2'd0, 32'h0000_00FF, 1'b0, "level_a");
    rd(2, 2'd0, 32'hFFFF_FFFF, 1'b0, "level_c");

    // Rising mode ignores the fall, then times the 0->5 rise cycle by cycle.
    in_a = 8'h00;
    idle(4);
    rd(0, 2'd3, 32'h0, 1'b0, "no_fall_cap_a");
    wr(2'd2, 32'h04);
    in_a = 8'h05;
    rd(0, 2'd3, 32'h0, 1'b0, "rise_t0");
    rd(0, 2'd3, 32'h0, 1'b0, "rise_t1");
    rd(0, 2'd3, 32'h0, 1'b1, "rise_t2");
    rd(0, 2'd3, 32'h05, 1'b1, "rise_t3");
    wr(2'd3, 32'h04);
    rd(0, 2'd3, 32'h01, 1'b0, "w1c_a");

    // Falling mode.
    wr(2'd2, 32'h01);
    in_b = 8'hFE;
    idle(4);
    rd(1, 2'd3, 32'h01, 1'b1, "fall_cap_b");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(1, 2'd3, 32'h0, 1'b0, "clr_b");
    in_b = 8'hFF;
    idle(4);
    rd(1, 2'd3, 32'h0, 1'b0, "no_rise_cap_b");
    in_b = 8'hFE;
    idle(4);
    rd(1, 2'd3, 32'h01, 1'b1, "fall_cap2_b");

    // Any-edge mode on the 32-bit, 3-stage instance.
    in_c = 32'hFFFF_FFF7;
    idle(5);
    rd(2, 2'd3, 32'h08, 1'b0, "any_fall_c");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2, 2'd3, 32'h0, 1'b0, "clr_c");
    in_c = 32'hFFFF_FFFF;
    idle(5);
    rd(2, 2'd3, 32'h08, 1'b0, "any_rise_c");
    wr(2'd2, 32'h08);
    rd(2, 2'd2, 32'h08, 1'b1, "mask_c");

    // New edge on bit 3 lands on the same edge as its W1C.
    in_c = 32'hFFFF_FFF7;
    idle(3);
    wr(2'd3, 32'h08);
    rd(2, 2'd3, 32'h08, 1'b1, "set_wins_c");

    // Reserved address and writes to read-only addresses.
    rd(2, 2'd1, 32'h0, 1'b1, "reserved_c");
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2, 2'd2, 32'h08, 1'b1, "mask_keep_c");
    rd(2, 2'd3, 32'h08, 1'b1, "cap_keep_c");
    rd(2, 2'd0, 32'hFFFF_FFF7, 1'b1, "level_c2");
    rd(0, 2'd1, 32'h0, 1'b0, "reserved_a");

    // Asynchronous reset mid-cycle.
    rd(2, 2'd3, 32'h08, 1'b1, "pre_reset_c");
    idle(1);
    chk("pre_rst_rd_c", rd_c, 32'h08);
    reset = 1'b1;
    #2;
    chk("async_rd_c", rd_c, 32'h0);
    chk("async_irq_c", {31'h0, irq_c}, 32'h0);
    idle(2);
    reset = 1'b0;
    idle(6);
    rd(0, 2'd3, 32'h0, 1'b0, "rearm_a");
    rd(2, 2'd2, 32'h0, 1'b0, "mask_rst_c");
    rd(2, 2'd3, 32'h0, 1'b0, "cap_rst_c");
    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
